// File: rtl/cdf_pkg.sv
// Shared types and default sizing for the parametrised CDF pass sequencer.
package cdf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_COMPUTE,
      ST_WRITE,
      ST_ADVANCE,
      ST_DONE
   } cdf_state_e;

   localparam int DEF_NUM_TILES      = 64;
   localparam int DEF_TILE_W         = 6;
   localparam int DEF_COMPUTE_CYCLES = 2;
   localparam int DEF_TIMEOUT        = 15;

endpackage

// File: rtl/cdf_tick_counter.sv
// Loadable down-counter with terminal-count flag; used for compute windows and read timeouts.
module cdf_tick_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - W'(1);
   end

   assign tc = (count == '0);

endmodule

// File: rtl/cdf_seq_ctrl.sv
// Sequences NUM_TILES read/compute/write CDF passes per image with handshakes, abort and read timeout.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for start
// ST_RD_ISSUE | one-cycle read strobe (rd_first on tile 0, else rd_next)
// ST_RD_WAIT  | waiting for rd_valid, bounded by TIMEOUT cycles
// ST_COMPUTE  | compute_en high for COMPUTE_CYCLES cycles
// ST_WRITE    | wr_req held until wr_ack
// ST_ADVANCE  | step tile index or finish image
// ST_DONE     | one-cycle cdf_done
module cdf_seq_ctrl
   import cdf_pkg::*;
#(
   parameter int NUM_TILES      = DEF_NUM_TILES,
   parameter int TILE_W         = DEF_TILE_W,
   parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              rd_first,
   output logic              rd_next,
   input  logic              rd_valid,
   output logic              compute_en,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [TILE_W-1:0] tile_idx,
   output logic              busy,
   output logic              cdf_done,
   output logic              rd_timeout
);

   localparam int CMP_W = $clog2(COMPUTE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CMP_W-1:0]  CMP_LOAD  = CMP_W'(COMPUTE_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT - 1);
   localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

   cdf_state_e        state_q, state_d;
   logic [TILE_W-1:0] tile_d;
   logic              cmp_load, cmp_en, cmp_tc;
   logic              to_load, to_en, to_tc;
   logic              set_timeout, start_ok;

   cdf_tick_counter #(.W(CMP_W)) u_cmp_cnt (
      .clk(clk), .reset(reset), .load(cmp_load), .load_val(CMP_LOAD), .en(cmp_en), .tc(cmp_tc)
   );

   cdf_tick_counter #(.W(TO_W)) u_to_cnt (
      .clk(clk), .reset(reset), .load(to_load), .load_val(TO_LOAD), .en(to_en), .tc(to_tc)
   );

   always_comb begin
      state_d     = state_q;
      tile_d      = tile_idx;
      cmp_load    = 1'b0;
      cmp_en      = 1'b0;
      to_load     = 1'b0;
      to_en       = 1'b0;
      set_timeout = 1'b0;
      start_ok    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               tile_d   = '0;
               state_d  = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            to_load = 1'b1;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            // a valid on the final allowed cycle wins over the timeout
            if (rd_valid) begin
               cmp_load = 1'b1;
               state_d  = ST_COMPUTE;
            end else if (to_tc) begin
               set_timeout = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               to_en = 1'b1;
            end
         end
         ST_COMPUTE: begin
            if (cmp_tc) state_d = ST_WRITE;
            else        cmp_en  = 1'b1;
         end
         ST_WRITE: begin
            if (wr_ack) state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            if (tile_idx == LAST_TILE) begin
               state_d = ST_DONE;
            end else begin
               tile_d  = tile_idx + TILE_W'(1);
               state_d = ST_RD_ISSUE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         tile_d      = tile_idx;
         set_timeout = 1'b0;
      end
   end

   // outputs are registered copies of the upcoming state so they line up with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tile_idx   <= '0;
         rd_first   <= 1'b0;
         rd_next    <= 1'b0;
         compute_en <= 1'b0;
         wr_req     <= 1'b0;
         busy       <= 1'b0;
         cdf_done   <= 1'b0;
         rd_timeout <= 1'b0;
      end else begin
         state_q    <= state_d;
         tile_idx   <= tile_d;
         rd_first   <= (state_d == ST_RD_ISSUE) && (tile_d == '0);
         rd_next    <= (state_d == ST_RD_ISSUE) && (tile_d != '0);
         compute_en <= (state_d == ST_COMPUTE);
         wr_req     <= (state_d == ST_WRITE);
         busy       <= (state_d != ST_IDLE);
         cdf_done   <= (state_d == ST_DONE);
         if (set_timeout)   rd_timeout <= 1'b1;
         else if (start_ok) rd_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdf_seq_ctrl.sv
// Randomised bench for cdf_seq_ctrl: bench acts as memory/write responder and predicts per-image timing.
module tb_cdf_seq_ctrl;

   localparam int NT = 4;
   localparam int TW = 2;
   localparam int CC = 2;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset, start, abort, rd_valid, wr_ack;
   logic          rd_first, rd_next, compute_en, wr_req, busy, cdf_done, rd_timeout;
   logic [TW-1:0] tile_idx;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_d [NT];
   int wr_a [NT];

   cdf_seq_ctrl #(.NUM_TILES(NT), .TILE_W(TW), .COMPUTE_CYCLES(CC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rd_first(rd_first), .rd_next(rd_next), .rd_valid(rd_valid),
      .compute_en(compute_en), .wr_req(wr_req), .wr_ack(wr_ack),
      .tile_idx(tile_idx), .busy(busy), .cdf_done(cdf_done), .rd_timeout(rd_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // cycles one tile occupies: issue, read latency, compute window, write with ack delay, advance
   function automatic int tile_cycles(input int i);
      return 1 + rd_d[i] + CC + (wr_a[i] + 1) + 1;
   endfunction

   task automatic set_nominal();
      foreach (rd_d[i]) begin
         rd_d[i] = 1;
         wr_a[i] = 0;
      end
   endtask

   task automatic run_image(input int abort_cyc, input int rst_tile, input bit noise);
      int  n_strobe, n_first, n_next, n_done, done_cyc, end_cyc, rd_cd, wcnt, to_tile, sum, cyc;
      int  comp [NT];
      int  wr [NT];
      bit  in_wr, stopped, aborting, resetting;
      n_strobe = 0; n_first = 0; n_next = 0; n_done = 0; done_cyc = 0; end_cyc = 0;
      rd_cd = -1; wcnt = 0; in_wr = 0; stopped = 0; aborting = 0; resetting = 0;
      foreach (comp[i]) begin
         comp[i] = 0;
         wr[i]   = 0;
      end
      to_tile = NT;
      for (int i = NT - 1; i >= 0; i--)
         if (rd_d[i] > TO) to_tile = i;

      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      while (!stopped && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0; abort = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
         if (resetting) begin
            reset = 1'b0;
            check_val("reset_outputs_zero",
                      {tile_idx, rd_first, rd_next, compute_en, wr_req, busy, cdf_done, rd_timeout}, 0);
         end
         if (aborting)
            check_val("abort_outputs_low", {rd_first, rd_next, compute_en, wr_req, busy, cdf_done}, 0);
         if (cyc == 1) check_val("timeout_clear_on_start", rd_timeout, 0);
         if (rd_first || rd_next) begin
            check_val("strobe_tile", tile_idx, n_strobe);
            check_val("strobe_kind_first", rd_first, (n_strobe == 0));
            rd_cd = (n_strobe < NT) ? rd_d[n_strobe] : 1;
            n_strobe++;
            n_first += rd_first;
            n_next  += rd_next;
         end else if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) rd_valid = 1'b1;
         end
         if (compute_en) comp[tile_idx]++;
         if (wr_req) begin
            wr[tile_idx]++;
            if (!in_wr) begin
               in_wr = 1'b1;
               wcnt  = (n_strobe > 0 && n_strobe <= NT) ? wr_a[n_strobe-1] : 0;
            end
            wr_ack = (wcnt == 0);
            if (wcnt > 0) wcnt--;
         end else begin
            in_wr = 1'b0;
         end
         if (cdf_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (!busy) begin
            end_cyc = cyc;
            stopped = 1'b1;
         end else begin
            if (cyc == abort_cyc) begin
               check_val("abort_in_compute", compute_en, 1);
               abort    = 1'b1;
               aborting = 1'b1;
            end
            if (rst_tile >= 0 && !resetting && wr_req && tile_idx == rst_tile && wr[rst_tile] == 2) begin
               reset     = 1'b1;
               resetting = 1'b1;
            end
            if (noise && cyc > 1 && $urandom_range(0, 5) == 0) start = 1'b1;
         end
      end
      start = 1'b0; abort = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0; reset = 1'b0;
      if (!stopped) check_val("run_cycle_budget", cyc, -1);

      if (abort_cyc > 0) begin
         check_val("abort_end_cycle", end_cyc, abort_cyc + 1);
         check_val("abort_no_done", n_done, 0);
      end else if (rst_tile >= 0) begin
         check_val("reset_reached_write", resetting, 1);
      end else if (to_tile == NT) begin
         sum = 0;
         for (int i = 0; i < NT; i++) sum += tile_cycles(i);
         check_val("rd_first_count", n_first, 1);
         check_val("rd_next_count", n_next, NT - 1);
         check_val("done_count", n_done, 1);
         check_val("done_cycle", done_cyc, sum + 1);
         check_val("busy_drop_cycle", end_cyc, sum + 2);
         check_val("timeout_flag_clear", rd_timeout, 0);
         for (int i = 0; i < NT; i++) begin
            check_val($sformatf("compute_cycles_t%0d", i), comp[i], CC);
            check_val($sformatf("wr_req_cycles_t%0d", i), wr[i], wr_a[i] + 1);
         end
      end else begin
         sum = 0;
         for (int i = 0; i < to_tile; i++) sum += tile_cycles(i);
         check_val("timeout_strobes", n_strobe, to_tile + 1);
         check_val("timeout_no_done", n_done, 0);
         check_val("timeout_busy_drop_cycle", end_cyc, sum + 1 + TO + 1);
         check_val("timeout_flag_set", rd_timeout, 1);
         for (int i = 0; i < NT; i++)
            check_val($sformatf("timeout_compute_t%0d", i), comp[i], (i < to_tile) ? CC : 0);
      end
   endtask

   task automatic idle_noise(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_ack = 1'($urandom_range(0, 1));
         check_val("idle_quiet", {rd_first, rd_next, compute_en, wr_req, busy, cdf_done}, 0);
      end
      wr_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_state",
                {tile_idx, rd_first, rd_next, compute_en, wr_req, busy, cdf_done, rd_timeout}, 0);
      reset = 1'b0;

      set_nominal();
      run_image(0, -1, 1'b0);
      idle_noise(3);

      set_nominal();
      wr_a[2] = 5;
      run_image(0, -1, 1'b0);

      set_nominal();
      rd_d[1] = 1000;
      run_image(0, -1, 1'b0);
      idle_noise(2);

      set_nominal();
      rd_d[0] = TO;
      run_image(0, -1, 1'b1);

      set_nominal();
      rd_d[2] = TO + 1;
      run_image(0, -1, 1'b0);

      set_nominal();
      run_image(21, -1, 1'b0);
      idle_noise(2);
      run_image(0, -1, 1'b1);

      set_nominal();
      wr_a[1] = 4;
      run_image(0, 1, 1'b0);
      idle_noise(2);

      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < NT; i++) begin
            rd_d[i] = ($urandom_range(0, 9) == 0) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(1, TO);
            wr_a[i] = $urandom_range(0, 4);
         end
         run_image(0, -1, 1'b1);
         idle_noise(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
